// File: rtl/bias_ctrl.sv
// bias_ctrl: per-channel bias sequencer for the three-lane bias-add stage.
// Optional stall counter output o_stall_cnt when BIAS_CTRL_PERF_EN is defined.
module bias_ctrl #(
    parameter int B_BW   = 8,
    parameter int CH_BW  = 6,
    parameter int PIX_BW = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_bias_we,
    input  logic [CH_BW-1:0]  i_bias_waddr,
    input  logic [B_BW-1:0]   i_bias_wdata,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [CH_BW:0]    i_num_ch,
    input  logic [PIX_BW-1:0] i_num_pix,
    input  logic              i_acc_valid,
    output logic              o_acc_ready,
    output logic              o_en,
    output logic [B_BW-1:0]   o_bias,
    output logic              o_valid,
    output logic [CH_BW-1:0]  o_ch_idx,
    output logic              o_busy,
    output logic              o_done
`ifdef BIAS_CTRL_PERF_EN
    ,
    output logic [15:0]       o_stall_cnt
`endif
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t            r_state;
    logic [B_BW-1:0]   r_rf [2**CH_BW];
    logic [CH_BW:0]    r_num_ch;
    logic [PIX_BW-1:0] r_num_pix;
    logic [CH_BW-1:0]  r_ch;
    logic [PIX_BW-1:0] r_pix;
    logic              w_beat;
    logic              w_last_pix;
    logic              w_last_ch;

    // Abort withdraws ready in the same cycle so no beat is consumed.
    assign o_acc_ready = (r_state == RUN) && !i_abort;
    assign w_beat      = o_acc_ready && i_acc_valid;
    assign o_en        = w_beat;
    assign w_last_pix  = r_pix == r_num_pix - PIX_BW'(1);
    assign w_last_ch   = {1'b0, r_ch} == r_num_ch - (CH_BW+1)'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2**CH_BW; i++) r_rf[i] <= '0;
        end else if (i_bias_we && r_state == IDLE) begin
            r_rf[i_bias_waddr] <= i_bias_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_num_ch  <= '0;
            r_num_pix <= '0;
            r_ch      <= '0;
            r_pix     <= '0;
            o_bias    <= '0;
            o_valid   <= 1'b0;
            o_ch_idx  <= '0;
            o_done    <= 1'b0;
            o_busy    <= 1'b0;
        end else begin
            o_valid <= w_beat;
            if (w_beat) o_ch_idx <= r_ch;
            o_done <= 1'b0;
            if (r_state != IDLE && i_abort) begin
                r_state <= IDLE;
                o_busy  <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: if (i_start) begin
                        r_num_ch  <= i_num_ch;
                        r_num_pix <= i_num_pix;
                        r_ch      <= '0;
                        r_pix     <= '0;
                        o_busy    <= 1'b1;
                        if (i_num_ch == '0 || i_num_pix == '0) begin
                            r_state <= DONE;
                            o_done  <= 1'b1;
                        end else begin
                            r_state <= LOAD;
                        end
                    end
                    LOAD: begin
                        o_bias  <= r_rf[r_ch];
                        r_state <= RUN;
                    end
                    RUN: if (w_beat) begin
                        if (w_last_pix) begin
                            r_pix <= '0;
                            if (w_last_ch) begin
                                r_state <= DONE;
                                o_done  <= 1'b1;
                            end else begin
                                r_ch    <= r_ch + CH_BW'(1);
                                r_state <= LOAD;
                            end
                        end else begin
                            r_pix <= r_pix + PIX_BW'(1);
                        end
                    end
                    DONE: begin
                        r_state <= IDLE;
                        o_busy  <= 1'b0;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

`ifdef BIAS_CTRL_PERF_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (r_state == IDLE && i_start) begin
            r_stall_cnt <= '0;
        end else if (r_state == RUN && !i_acc_valid && r_stall_cnt != 16'hFFFF) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign o_stall_cnt = r_stall_cnt;
`endif
endmodule
